// File: rtl/gpu_pkg.sv
// Shared types for the pixel pipeline: FSM states, screen defaults and the
// framebuffer write entry carried through the write-stage FIFO.
package gpu_pkg;

  localparam int H_RES_DEF   = 256;
  localparam int V_RES_DEF   = 120;
  localparam int ADDR_W_DEF  = 15;
  localparam int COLOR_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  addr;
    logic [COLOR_W_DEF-1:0] color;
  } pix_entry_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO, DEPTH entries of W bits; head visible the cycle after push.
// Push when full and pop when empty are ignored; pointers carry a wrap bit.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 23
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign head_dat = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/pixel_write_stage.sv
// Clips drawer coordinates, buffers framebuffer writes, drains them under mem_ack.
// Accepted pixel reaches mem_we one cycle later; define PIXEL_DEDUP_EN to drop repeated addresses.
module pixel_write_stage
  import gpu_pkg::*;
#(
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COLOR_W-1:0] pix_color,
  input  logic               in_valid,
  input  logic [8:0]         in_x,
  input  logic [7:0]         in_y,
  output logic               in_ready,
  input  logic               draw_done,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  input  logic               mem_ack,
  output logic [15:0]        pix_written,
  output logic [15:0]        pix_clipped,
  output logic               write_done
);

  state_t             state;
  logic [COLOR_W-1:0] color_q;
  logic               fifo_full;
  logic               fifo_empty;
  logic               hs;
  logic               visible;
  logic               push;
  logic               pop;
  logic               start_ok;
  logic [ADDR_W-1:0]  pix_addr;
  pix_entry_t         push_ent;
  pix_entry_t         head_ent;

  assign in_ready = (state == ACTIVE) && !fifo_full;
  assign hs       = in_valid && in_ready;
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  // Sign bit set means negative, which is always off-screen.
  assign visible  = !in_x[8] && (32'(in_x[7:0]) < 32'(H_RES)) &&
                    !in_y[7] && (32'(in_y[6:0]) < 32'(V_RES));
  assign pix_addr = ADDR_W'(32'(in_y[6:0]) * 32'(H_RES) + 32'(in_x[7:0]));

`ifdef PIXEL_DEDUP_EN
  logic [ADDR_W-1:0] last_addr;
  logic              last_vld;

  assign push = hs && visible && !(last_vld && (last_addr == pix_addr));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_addr <= '0;
      last_vld  <= 1'b0;
    end else if (start_ok) begin
      last_vld  <= 1'b0;
    end else if (push) begin
      last_addr <= pix_addr;
      last_vld  <= 1'b1;
    end
  end
`else
  assign push = hs && visible;
`endif

  assign push_ent.addr  = ADDR_W_DEF'(pix_addr);
  assign push_ent.color = COLOR_W_DEF'(color_q);

  pixel_fifo #(.DEPTH(DEPTH), .W($bits(pix_entry_t))) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign mem_we   = !fifo_empty;
  assign pop      = mem_we && mem_ack;
  assign mem_addr = fifo_empty ? '0 : ADDR_W'(head_ent.addr);
  assign mem_data = fifo_empty ? '0 : COLOR_W'(head_ent.color);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      write_done <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (start) state <= ACTIVE;
        ACTIVE:  if (draw_done && !hs) state <= DRAIN;
        DRAIN:   if (fifo_empty) begin
                   state      <= DONE;
                   write_done <= 1'b1;
                 end
        DONE:    if (start) begin
                   state      <= ACTIVE;
                   write_done <= 1'b0;
                 end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      color_q     <= '0;
      pix_written <= '0;
      pix_clipped <= '0;
    end else if (start_ok) begin
      color_q     <= pix_color;
      pix_written <= '0;
      pix_clipped <= '0;
    end else begin
      if (pop && (pix_written != 16'hFFFF))
        pix_written <= pix_written + 16'd1;
      if (hs && !visible && (pix_clipped != 16'hFFFF))
        pix_clipped <= pix_clipped + 16'd1;
    end
  end

endmodule

// File: tb/tb_pixel_write_stage.sv
// Directed bench for pixel_write_stage: expected writes go into a queue at
// handshake time and a negedge monitor compares every committed write.
module tb_pixel_write_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  pix_color = '0;
  logic        in_valid = 1'b0;
  logic [8:0]  in_x = '0;
  logic [7:0]  in_y = '0;
  logic        in_ready;
  logic        draw_done = 1'b0;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ack = 1'b0;
  logic [15:0] pix_written;
  logic [15:0] pix_clipped;
  logic        write_done;

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;
  logic [7:0]  cur_color = '0;
  logic [22:0] exp_q [$];

  always #5 clk = ~clk;

  pixel_write_stage dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pix_color   (pix_color),
    .in_valid    (in_valid),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_ready    (in_ready),
    .draw_done   (draw_done),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ack     (mem_ack),
    .pix_written (pix_written),
    .pix_clipped (pix_clipped),
    .write_done  (write_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: every committed write must match the head of the expected queue.
  initial begin
    logic [22:0] e;
    forever begin
      @(negedge clk);
      if (reset && mem_we && mem_ack) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", mem_addr, mem_data);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", 32'(mem_addr), 32'(e[22:8]));
          chk("write_data", 32'(mem_data), 32'(e[7:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic start_prim(input logic [7:0] c);
    @(posedge clk); #1;
    start = 1'b1; pix_color = c; cur_color = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [8:0] x, input logic [7:0] y,
                      input bit exp_push, input logic [14:0] exp_addr);
    bit got = 0;
    in_valid = 1'b1; in_x = x; in_y = y;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1;
    end
    if (!got) chk("send_accept", 32'(in_ready), 32'd1);
    else begin
      @(posedge clk);
      if (exp_push) exp_q.push_back({exp_addr, cur_color});
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic finish_prim();
    bit got = 0;
    draw_done = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (write_done) got = 1;
    end
    chk("finish_write_done", 32'(write_done), 32'd1);
    @(posedge clk); #1;
    draw_done = 1'b0;
  endtask

  initial begin
    int n;
    int ws;
    bit got;
    logic [14:0] head0;

    // Reset state
    #12;
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_data", 32'(mem_data), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_written", 32'(pix_written), 0);
    chk("rst_clipped", 32'(pix_clipped), 0);
    chk("rst_write_done", 32'(write_done), 0);
    @(posedge clk); #1 reset = 1'b1;

    // 1: single visible pixel, one-cycle latency
    mem_ack = 1'b1;
    start_prim(8'h3C);
    send(9'd10, 8'd5, 1, 15'd1290);
    chk("t1_latency_mem_we", 32'(mem_we), 1);
    chk("t1_mem_addr", 32'(mem_addr), 1290);
    chk("t1_mem_data", 32'(mem_data), 32'h3C);
    repeat (2) @(negedge clk);
    chk("t1_written", 32'(pix_written), 1);
    finish_prim();

    // 2: all-clipped coordinates
    start_prim(8'h42);
    ws = writes_seen;
    send(9'h1FF, 8'd0, 0, 0);
    send(9'd256, 8'd3, 0, 0);
    send(9'd0, 8'd120, 0, 0);
    send(9'd5, 8'hFE, 0, 0);
    repeat (3) @(negedge clk);
    chk("t2_mem_we", 32'(mem_we), 0);
    chk("t2_clipped", 32'(pix_clipped), 4);
    chk("t2_written", 32'(pix_written), 0);
    chk("t2_no_writes", 32'(writes_seen - ws), 0);
    finish_prim();

    // 3: back-pressure, FIFO fills at DEPTH=4
    start_prim(8'h55);
    mem_ack = 1'b0;
    send(9'd0, 8'd0, 1, 15'd0);
    send(9'd1, 8'd0, 1, 15'd1);
    send(9'd255, 8'd119, 1, 15'd30719);
    send(9'd2, 8'd1, 1, 15'd258);
    in_valid = 1'b1; in_x = 9'd3; in_y = 8'd1;
    @(negedge clk);
    head0 = mem_addr;
    for (int i = 0; i < 4; i++) begin
      chk("t3_in_ready_low", 32'(in_ready), 0);
      chk("t3_head_stable", 32'(mem_addr), 0);
      @(negedge clk);
    end
    chk("t3_head_first", 32'(head0), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    mem_ack = 1'b1;
    repeat (6) @(negedge clk);
    chk("t3_written", 32'(pix_written), 4);
    chk("t3_queue_drained", 32'(exp_q.size()), 0);
    finish_prim();

    // 4: drain with back-pressure, write_done timing
    start_prim(8'hA0);
    mem_ack = 1'b0;
    send(9'd20, 8'd1, 1, 15'd276);
    send(9'd21, 8'd1, 1, 15'd277);
    send(9'd22, 8'd1, 1, 15'd278);
    draw_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_write_done_low", 32'(write_done), 0);
    chk("t4_mem_we_held", 32'(mem_we), 1);
    @(posedge clk); #1;
    mem_ack = 1'b1;
    got = 0; n = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      n++;
      if (write_done) got = 1;
    end
    chk("t4_write_done", 32'(write_done), 1);
    chk("t4_done_cycles", 32'(n), 5);
    chk("t4_written", 32'(pix_written), 3);
    @(posedge clk); #1;
    draw_done = 1'b0;

    // 5: reset mid-burst discards queued writes
    start_prim(8'h11);
    mem_ack = 1'b0;
    send(9'd30, 8'd2, 1, 15'd542);
    send(9'd31, 8'd2, 1, 15'd543);
    send(9'd40, 8'd200, 0, 0);
    send(9'd32, 8'd2, 1, 15'd544);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("t5_mem_we", 32'(mem_we), 0);
    chk("t5_written", 32'(pix_written), 0);
    chk("t5_clipped", 32'(pix_clipped), 0);
    chk("t5_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    mem_ack = 1'b1;
    ws = writes_seen;
    repeat (8) @(negedge clk);
    chk("t5_no_writes", 32'(writes_seen - ws), 0);
    chk("t5_mem_we_after", 32'(mem_we), 0);

    // 6: repeated address handling
    start_prim(8'h77);
    ws = writes_seen;
    send(9'd7, 8'd7, 1, 15'd1799);
`ifdef PIXEL_DEDUP_EN
    send(9'd7, 8'd7, 0, 15'd1799);
`else
    send(9'd7, 8'd7, 1, 15'd1799);
`endif
    send(9'd8, 8'd7, 1, 15'd1800);
    repeat (4) @(negedge clk);
    chk("t6_clipped", 32'(pix_clipped), 0);
`ifdef PIXEL_DEDUP_EN
    chk("t6_written", 32'(pix_written), 2);
    chk("t6_writes_seen", 32'(writes_seen - ws), 2);
`else
    chk("t6_written", 32'(pix_written), 3);
    chk("t6_writes_seen", 32'(writes_seen - ws), 3);
`endif
    finish_prim();
    chk("t6_queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_write_stage.md
Name: pixel_write_stage

Overview:
- Downstream consumer of the circle drawing stage. Takes a stream of signed pixel coordinates (x_out/y_out plus done_out from the drawer) and clips each one to the visible screen.
- Converts each surviving pixel to a linear framebuffer address and buffers it in a small FIFO. Drains the FIFO to a single-port framebuffer write interface that supports back-pressure.
- Reports completion once the drawer signals done and every buffered pixel has been committed.

Parameters:
- H_RES, 256, visible width in pixels; valid x is 0..H_RES-1
- V_RES, 120, visible height in pixels; valid y is 0..V_RES-1
- ADDR_W, 15, framebuffer address width; must satisfy H_RES*V_RES <= 2^ADDR_W
- COLOR_W, 8, pixel colour width
- DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a new primitive; clears counters
- pix_color  in  COLOR_W  colour applied to every pixel of the current primitive; sampled on start
- in_valid  in  1  coordinate valid
- in_x  in  9  signed x
- in_y  in  8  signed y
- in_ready  out  1  stage can accept a coordinate
- draw_done  in  1  upstream done level
- mem_we  out  1  write request
- mem_addr  out  ADDR_W  write address
- mem_data  out  COLOR_W  write data
- mem_ack  in  1  framebuffer accepted the current write
- pix_written  out  16  writes committed (mem_we && mem_ack) since start
- pix_clipped  out  16  coordinates dropped by clipping since start
- write_done  out  1  primitive fully committed

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, FIFO empty, mem_we=0, mem_addr=0, mem_data=0, in_ready=0, pix_written=0, pix_clipped=0, write_done=0, latched colour=0.
  - Reset mid-operation discards all FIFO contents. No partial write is replayed.
- FSM states:
  - IDLE -> ACTIVE on start.
  - ACTIVE -> DRAIN when draw_done=1 and no handshake (in_valid && in_ready) occurs that cycle.
  - DRAIN -> DONE when the FIFO is empty and mem_we=0.
  - DONE -> ACTIVE on start.
  - start in ACTIVE or DRAIN is ignored.
- On start: both counters clear to 0, write_done clears to 0, pix_color is latched.
- in_ready = 1 only in ACTIVE with FIFO not full. It is derived from registered state only; there is no full-with-pop bypass.
- Handshake occurs when in_valid && in_ready. The coordinate is then clipped:
  - Visible if 0 <= in_x < H_RES and 0 <= in_y < V_RES (signed compares; negative values are always clipped).
  - Visible: push {addr = in_y*H_RES + in_x, truncated to ADDR_W; latched colour}.
  - Clipped: no push; pix_clipped increments.
- Output side:
  - mem_we = FIFO non-empty; mem_addr/mem_data present the FIFO head.
  - Head stays stable while mem_we && !mem_ack.
  - Pop when mem_we && mem_ack; pix_written increments.
  - mem_ack while mem_we=0 is ignored.
- Latency: a pixel accepted at cycle N into an empty FIFO appears on mem_we at cycle N+1.
- Simultaneous push and pop: allowed when the FIFO is not full; occupancy is unchanged.
- Counters saturate at 16'hFFFF.
- write_done is 1 in DONE, 0 elsewhere.

Optional Feature:
- Macro PIXEL_DEDUP_EN.
- When defined: a visible pixel whose address equals the last pushed address since start is dropped. It does not count as clipped and is not pushed. This suppresses the octant duplicates produced at x=0 and at x=y. The last-address register is invalidated on start and on reset.
- When undefined: every visible pixel is pushed.

Decomposition:
- Shared package gpu_pkg holds:
  - FSM state typedef (IDLE, ACTIVE, DRAIN, DONE)
  - default H_RES/V_RES/ADDR_W constants
  - pixel entry struct {addr, color}
- Sub-module pixel_fifo: synchronous FIFO with async active-low reset, parameterised by DEPTH and entry width, with push/pop/full/empty outputs.
- Clipping and address arithmetic stay in the top module.

Test Plan:
1. Reset, then start with pix_color=8'h3C; push (10,5) with mem_ack=1 -> next cycle mem_we=1, mem_addr=1290, mem_data=3C; pix_written=1.
2. Push (-1,0), (256,3), (0,120), (5,-2) -> no mem_we ever asserts, pix_clipped=4, pix_written=0.
3. Hold mem_ack=0 and push 5 visible pixels -> in_ready falls after 4 accepts and head address stays stable; release mem_ack -> 4 writes in order, pix_written=4.
4. Push 3 pixels with mem_ack=0, raise draw_done -> state DRAIN, write_done=0; release mem_ack -> write_done=1 the cycle after the last pop.
5. Assert reset=0 mid-burst with 3 entries queued -> mem_we=0 and counters 0 immediately, no further writes after release.
6. With PIXEL_DEDUP_EN defined, push (7,7) twice then (8,7) -> exactly 2 writes (1799, 1800), pix_clipped=0; without the macro -> 3 writes.
